// File: rtl/torgb_mul_pipe.sv
// torgb_mul_pipe: pipelined multiplier for the colour-matrix stage.
// Each operand is widened by one bit (sign- or zero-extended), the exact
// product is rounded, arithmetically shifted and optionally saturated or
// clamped. A valid bit travels with every slot; data is never valid-gated.
module torgb_mul_pipe #(
  parameter int DIN0_WIDTH  = 32,
  parameter int DIN1_WIDTH  = 34,
  parameter int DOUT_WIDTH  = 65,
  parameter int NUM_STAGE   = 2,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SAT_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_ovf
);

  // Product width, rounded-sum width, and a comparison width wide enough to
  // hold both the shifted result and the clamp limits (2^DOUT_WIDTH needs
  // DOUT_WIDTH+2 signed bits).
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int SW = PW + 1;
  localparam int XW = (SW > DOUT_WIDTH + 2) ? SW : DOUT_WIDTH + 2;
  // Result registers after the datapath; with one stage there is no operand
  // register, so the single register sits behind the datapath.
  localparam int RS = (NUM_STAGE >= 2) ? NUM_STAGE - 1 : 1;

  localparam logic signed [SW-1:0] RND_SW =
    (ROUND != 0 && SHIFT > 0) ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : SW'(0);
  localparam logic signed [XW-1:0] ONE_X = XW'(1);
  localparam logic signed [XW-1:0] SMAX  = (ONE_X <<< (DOUT_WIDTH - 1)) - ONE_X;
  localparam logic signed [XW-1:0] SMIN  = -(ONE_X <<< (DOUT_WIDTH - 1));
  localparam logic signed [XW-1:0] UMAX  = (ONE_X <<< DOUT_WIDTH) - ONE_X;

  logic [DIN0_WIDTH-1:0] op0;
  logic [DIN1_WIDTH-1:0] op1;
  logic                  op_vld;

  generate
    if (NUM_STAGE >= 2) begin : g_op_reg
      logic [DIN0_WIDTH-1:0] op0_q;
      logic [DIN1_WIDTH-1:0] op1_q;
      logic                  op_vld_q;

      // Operand capture on every enabled edge; in_valid only tags the slot.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          op0_q    <= '0;
          op1_q    <= '0;
          op_vld_q <= 1'b0;
        end else if (ce) begin
          op0_q    <= din0;
          op1_q    <= din1;
          op_vld_q <= in_valid;
        end
      end

      assign op0    = op0_q;
      assign op1    = op1_q;
      assign op_vld = op_vld_q;
    end else begin : g_op_bypass
      assign op0    = din0;
      assign op1    = din1;
      assign op_vld = in_valid;
    end
  endgenerate

  logic                  sx0_d;
  logic                  sx1_d;
  logic signed [PW-1:0]  a_ext_d;
  logic signed [PW-1:0]  b_ext_d;
  logic signed [PW-1:0]  prod_d;
  logic signed [SW-1:0]  rnd_sum_d;
  logic signed [SW-1:0]  shifted_d;
  logic signed [XW-1:0]  shifted_x_d;
  logic [DOUT_WIDTH-1:0] res_d;
  logic                  ovf_d;

  // Extend, multiply, round, shift and saturate/clamp the current operands.
  always_comb begin
    sx0_d       = (DIN0_SIGNED != 0) & op0[DIN0_WIDTH-1];
    sx1_d       = (DIN1_SIGNED != 0) & op1[DIN1_WIDTH-1];
    a_ext_d     = PW'(signed'({sx0_d, op0}));
    b_ext_d     = PW'(signed'({sx1_d, op1}));
    prod_d      = a_ext_d * b_ext_d;
    rnd_sum_d   = SW'(prod_d) + RND_SW;
    shifted_d   = rnd_sum_d >>> SHIFT;
    shifted_x_d = XW'(shifted_d);
    res_d       = shifted_x_d[DOUT_WIDTH-1:0];
    ovf_d       = 1'b0;
    if (SAT_MODE == 1) begin
      if (shifted_x_d > SMAX) begin
        res_d = SMAX[DOUT_WIDTH-1:0];
        ovf_d = 1'b1;
      end else if (shifted_x_d < SMIN) begin
        res_d = SMIN[DOUT_WIDTH-1:0];
        ovf_d = 1'b1;
      end
    end else if (SAT_MODE == 2) begin
      if (shifted_x_d[XW-1]) begin
        res_d = '0;
        ovf_d = 1'b1;
      end else if (shifted_x_d > UMAX) begin
        res_d = UMAX[DOUT_WIDTH-1:0];
        ovf_d = 1'b1;
      end
    end
  end

  logic [DOUT_WIDTH-1:0] res_q [RS];
  logic                  ovf_q [RS];
  logic                  vld_q [RS];

  // Result delay line; stalls as a whole when ce is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RS; i++) begin
        res_q[i] <= '0;
        ovf_q[i] <= 1'b0;
        vld_q[i] <= 1'b0;
      end
    end else if (ce) begin
      res_q[0] <= res_d;
      ovf_q[0] <= ovf_d;
      vld_q[0] <= op_vld;
      for (int i = 1; i < RS; i++) begin
        res_q[i] <= res_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign dout      = res_q[RS-1];
  assign out_ovf   = ovf_q[RS-1];
  assign out_valid = vld_q[RS-1];

endmodule

// File: tb/tb_torgb_mul_pipe.sv
// tb_torgb_mul_pipe: directed vectors on several configurations, plus a
// stalled stream and a mid-stream reset on NUM_STAGE = 1..4.
module tb_torgb_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic ce;
  logic in_valid;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Default configuration
  logic [31:0] a_d0;
  logic [33:0] a_d1;
  logic        a_vld;
  logic [64:0] a_dout;
  logic        a_ovf;

  torgb_mul_pipe u_a (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
    .din0(a_d0), .din1(a_d1), .out_valid(a_vld), .dout(a_dout), .out_ovf(a_ovf)
  );

  // 16x16 -> 8 configurations: 0 u*u round clamp, 1 u*u no-round clamp,
  // 2 s*u round clamp, 3 s*u round saturate
  logic [15:0] q_d0   [4];
  logic [15:0] q_d1   [4];
  logic        q_vld  [4];
  logic [7:0]  q_dout [4];
  logic        q_ovf  [4];

  torgb_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(8), .DIN0_SIGNED(0),
    .DIN1_SIGNED(0), .SHIFT(8), .ROUND(1), .SAT_MODE(2)) u_q0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
    .din0(q_d0[0]), .din1(q_d1[0]), .out_valid(q_vld[0]), .dout(q_dout[0]), .out_ovf(q_ovf[0]));
  torgb_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(8), .DIN0_SIGNED(0),
    .DIN1_SIGNED(0), .SHIFT(8), .ROUND(0), .SAT_MODE(2)) u_q1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
    .din0(q_d0[1]), .din1(q_d1[1]), .out_valid(q_vld[1]), .dout(q_dout[1]), .out_ovf(q_ovf[1]));
  torgb_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(8), .DIN0_SIGNED(1),
    .DIN1_SIGNED(0), .SHIFT(8), .ROUND(1), .SAT_MODE(2)) u_q2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
    .din0(q_d0[2]), .din1(q_d1[2]), .out_valid(q_vld[2]), .dout(q_dout[2]), .out_ovf(q_ovf[2]));
  torgb_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(8), .DIN0_SIGNED(1),
    .DIN1_SIGNED(0), .SHIFT(8), .ROUND(1), .SAT_MODE(1)) u_q3 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
    .din0(q_d0[3]), .din1(q_d1[3]), .out_valid(q_vld[3]), .dout(q_dout[3]), .out_ovf(q_ovf[3]));

  // Stream configurations: s8 x u8 -> 12 bits, shift 2, round, saturate
  logic [7:0]  e_d0;
  logic [7:0]  e_d1;
  logic        e_vld  [4];
  logic [11:0] e_dout [4];
  logic        e_ovf  [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_e
      torgb_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(12), .NUM_STAGE(gi + 1),
        .DIN0_SIGNED(1), .DIN1_SIGNED(0), .SHIFT(2), .ROUND(1), .SAT_MODE(1)) u_e (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .din0(e_d0), .din1(e_d1), .out_valid(e_vld[gi]), .dout(e_dout[gi]), .out_ovf(e_ovf[gi]));
    end
  endgenerate

  // History of samples accepted on ce-high edges since the last reset
  logic       h_vld [256];
  logic [7:0] h_d0  [256];
  logic [7:0] h_d1  [256];
  int         m;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // {ovf, dout} for the stream configuration
  function automatic logic [12:0] e_model(input logic [7:0] d0, input logic [7:0] d1);
    int p;
    int s;
    p = int'($signed(d0)) * int'(d1);
    s = (p + 2) >>> 2;
    if (s > 2047) return {1'b1, 12'h7FF};
    if (s < -2048) return {1'b1, 12'h800};
    return {1'b0, s[11:0]};
  endfunction

  task automatic check_e();
    for (int s = 0; s < 4; s++) begin
      int          ns;
      logic        ev;
      logic [12:0] em;
      ns = s + 1;
      ev = (m >= ns) ? h_vld[m-ns] : 1'b0;
      check($sformatf("ns%0d_vld_m%0d", ns, m), 128'(e_vld[s]), 128'(ev));
      if (ev) begin
        em = e_model(h_d0[m-ns], h_d1[m-ns]);
        check($sformatf("ns%0d_dout_m%0d", ns, m), 128'(e_dout[s]), 128'(em[11:0]));
        check($sformatf("ns%0d_ovf_m%0d", ns, m), 128'(e_ovf[s]), 128'(em[12]));
      end
    end
  endtask

  task automatic run_stream(input int ncyc, input int nsamp, input bit rand_ce);
    int sent = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_e();
      ce       = (rand_ce && c < ncyc - 12) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = (sent < nsamp);
      e_d0     = 8'($urandom);
      e_d1     = 8'($urandom);
      @(posedge clk);
      if (ce && m < 256) begin
        h_vld[m] = in_valid;
        h_d0[m]  = e_d0;
        h_d1[m]  = e_d1;
        m++;
        if (in_valid) sent++;
      end
    end
    check("stream_sent", 128'(sent), 128'(nsamp));
  endtask

  task automatic wait_result();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_q(input int i, input string tag, input logic [7:0] ed, input logic eo);
    check($sformatf("q%0d_%s_vld", i, tag), 128'(q_vld[i]), 128'(1'b1));
    check($sformatf("q%0d_%s_dout", i, tag), 128'(q_dout[i]), 128'(ed));
    check($sformatf("q%0d_%s_ovf", i, tag), 128'(q_ovf[i]), 128'(eo));
  endtask

  initial begin
    reset_n  = 1'b0;
    ce       = 1'b0;
    in_valid = 1'b0;
    a_d0 = '0; a_d1 = '0; e_d0 = '0; e_d1 = '0;
    for (int i = 0; i < 4; i++) begin q_d0[i] = '0; q_d1[i] = '0; end
    m = 0;

    #12;
    check("rst_a_vld",  128'(a_vld),  128'(1'b0));
    check("rst_a_dout", 128'(a_dout), 128'(65'd0));
    check("rst_a_ovf",  128'(a_ovf),  128'(1'b0));
    check("rst_e4_vld", 128'(e_vld[3]), 128'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    // Round 1
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1;
    a_d0 = 32'hFFFF_FFFD; a_d1 = 34'd5;
    q_d0[0] = 16'd300;   q_d1[0] = 16'd256;
    q_d0[1] = 16'd3;     q_d1[1] = 16'd128;
    q_d0[2] = 16'hFFFB;  q_d1[2] = 16'd256;
    q_d0[3] = 16'hFF38;  q_d1[3] = 16'd256;
    wait_result();
    check("a_m3x5_vld",  128'(a_vld),  128'(1'b1));
    check("a_m3x5_dout", 128'(a_dout), 128'(65'h1_FFFF_FFFF_FFFF_FFF1));
    check("a_m3x5_ovf",  128'(a_ovf),  128'(1'b0));
    check_q(0, "300x256", 8'd255, 1'b1);
    check_q(1, "3x128_noround", 8'd1, 1'b0);
    check_q(2, "m5x256", 8'd0, 1'b1);
    check_q(3, "m200x256", 8'h80, 1'b1);

    // Round 2
    a_d0 = 32'hFFFF_FFFF; a_d1 = 34'h2_0000_0000;
    q_d0[0] = 16'd3;     q_d1[0] = 16'd128;
    q_d0[1] = 16'd300;   q_d1[1] = 16'd256;
    q_d0[2] = 16'd100;   q_d1[2] = 16'd2;
    q_d0[3] = 16'd100;   q_d1[3] = 16'd256;
    wait_result();
    check("a_din1_unsigned_dout", 128'(a_dout), 128'(65'h1_FFFF_FFFE_0000_0000));
    check("a_din1_unsigned_ovf",  128'(a_ovf),  128'(1'b0));
    check_q(0, "3x128_round", 8'd2, 1'b0);
    check_q(1, "300x256_noround", 8'd255, 1'b1);
    check_q(2, "100x2", 8'd1, 1'b0);
    check_q(3, "100x256", 8'd100, 1'b0);

    // Round 3
    a_d0 = 32'd7; a_d1 = 34'h3_FFFF_FFFF;
    q_d0[0] = 16'hFFFF;  q_d1[0] = 16'hFFFF;
    q_d0[1] = 16'd255;   q_d1[1] = 16'd256;
    q_d0[2] = 16'd0;     q_d1[2] = 16'd0;
    q_d0[3] = 16'd128;   q_d1[3] = 16'd256;
    wait_result();
    check("a_7xmax_dout", 128'(a_dout), 128'(65'h0_0000_001B_FFFF_FFF9));
    check_q(0, "maxxmax", 8'd255, 1'b1);
    check_q(1, "255x256", 8'd255, 1'b0);
    check_q(2, "0x0", 8'd0, 1'b0);
    check_q(3, "128x256", 8'h7F, 1'b1);

    // Stalled stream on NUM_STAGE 1..4, from a clean reset
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    m = 0;
    run_stream(60, 10, 1'b1);

    // Three samples in flight, then reset between edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ce = 1'b1; in_valid = 1'b1;
      e_d0 = 8'd100 + 8'(i); e_d1 = 8'd200;
      @(posedge clk);
    end
    #2;
    reset_n = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("midrst_ns%0d_vld", s + 1),  128'(e_vld[s]),  128'(1'b0));
      check($sformatf("midrst_ns%0d_dout", s + 1), 128'(e_dout[s]), 128'(12'd0));
      check($sformatf("midrst_ns%0d_ovf", s + 1),  128'(e_ovf[s]),  128'(1'b0));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    m = 0;
    run_stream(20, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/torgb_mul_pipe.md
# torgb_mul_pipe

- Parametrised pipelined multiplier for the YUV→RGB conversion datapath.
- Computes the product of two operands. Each operand's signedness is set by parameter.
- The product then passes through optional round-half-up, arithmetic right shift and output saturation/clamp.
- Pipeline depth (1–4 stages) is configurable; a valid bit travels alongside the data.
- Replaces the fixed 2-stage signed×unsigned multiplier cores in the colour-matrix stage.
- Can emit 8-bit clamped colour components directly.

## Interface
- DIN0_WIDTH, 32, width of operand 0 (2–64)
- DIN1_WIDTH, 34, width of operand 1 (2–64)
- DOUT_WIDTH, 65, result width (2–128)
- NUM_STAGE, 2, register stages from input to output (1–4)
- DIN0_SIGNED, 1, 1 = din0 is two's complement, 0 = unsigned
- DIN1_SIGNED, 0, 1 = din1 is two's complement, 0 = unsigned
- SHIFT, 0, arithmetic right shift applied to the product (0–PW-1)
- ROUND, 0, 1 = add 2^(SHIFT-1) before the shift; ignored when SHIFT=0
- SAT_MODE, 0, 0 = wrap (truncate or sign-extend), 1 = signed saturate, 2 = unsigned clamp [0, 2^DOUT_WIDTH-1]

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; low freezes every pipeline register
- in_valid  in  1  din0/din1 carry a sample this cycle
- din0  in  DIN0_WIDTH  operand 0
- din1  in  DIN1_WIDTH  operand 1
- out_valid  out  1  dout/out_ovf carry a result
- dout  out  DOUT_WIDTH  result
- out_ovf  out  1  saturation/clamp changed the value (always 0 when SAT_MODE=0)

## Operation
- Operand extension: each operand is extended by one bit, sign-extended if its SIGNED parameter is 1, zero-extended otherwise.
- Product: P = ext(din0) × ext(din1), signed, PW = DIN0_WIDTH+DIN1_WIDTH+2 bits. Exact, never overflows.
- Round: R = P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed at PW+1 bits.
- Shift: S = R >>> SHIFT (arithmetic).
- Output, SAT_MODE=0: dout = low DOUT_WIDTH bits of S, or S sign-extended if DOUT_WIDTH exceeds its width; out_ovf=0.
- Output, SAT_MODE=1: clamp S to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; out_ovf=1 iff clamped.
- Output, SAT_MODE=2: clamp S to [0, 2^DOUT_WIDTH-1]; out_ovf=1 iff clamped.
- Data enters the pipeline on every ce-enabled edge regardless of in_valid. in_valid only sets the tracking bit.
- Data registers are not gated by valid; invalid slots may carry any value, and dout is don't-care while out_valid=0.
- Stage placement (operand regs, partial products, round/sat) is implementation-chosen. Output must be bit-exact to the equations above.
- No back-pressure: the consumer accepts every out_valid result.

## Timing
- Latency: a sample presented at ce-enabled edge k appears on dout/out_valid/out_ovf after edge k+NUM_STAGE-1, i.e. valid during the cycle following that edge. Count only ce-high edges.
- Throughput: one sample per ce-high cycle.
- ce=0: all data, valid and ovf registers hold. Outputs stay stable for the whole stall. Inputs presented during the stall are ignored.
- reset_n low (asynchronous, any cycle, mid-stream included): every valid bit, out_ovf and all data registers clear to 0 immediately.
  - dout=0, out_valid=0, out_ovf=0.
  - In-flight samples are discarded; none reappear after release.
- Reset release: first out_valid no earlier than NUM_STAGE ce-high edges after the first in_valid=1 sample.
- NUM_STAGE=1: output registered directly from inputs, with no combinational path from input to output.

## Test plan
- Defaults, in_valid=1, din0=32'hFFFFFFFD (−3), din1=5 → two edges later out_valid=1, dout=−15 (65-bit all ones except low bits 1110001), out_ovf=0.
- Defaults, din0=−1, din1=34'h200000000 (unsigned 2^33) → dout=−2^33; the bench also checks din1 is not read as signed.
- DIN0/DIN1=16, DOUT_WIDTH=8, SHIFT=8, ROUND=1, SAT_MODE=2, unsigned×unsigned:
  - 300×256 → dout=255, ovf=1
  - 3×128 → dout=2 (384+128=512>>8), ovf=0; with ROUND=0 → 1
- Same configuration with DIN0_SIGNED=1: −5×256 → dout=0, ovf=1. With SAT_MODE=1 and DOUT_WIDTH=8: −200×256 → dout=−128, ovf=1.
- Back-to-back stream of 10 samples with ce toggled 0/1 on random cycles, NUM_STAGE=1..4 → output order and values match the model; outputs frozen during every ce=0 cycle.
- reset_n pulsed low asynchronously (between edges) with 3 samples in flight → out_valid/dout/out_ovf drop to 0 before the next edge; after release, only new samples emerge, at correct latency.
